// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Define SEQ_MUL_BCD_EN to add a double-dabble stage and the packed-BCD output bcd.
module seq_multiplier #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef SEQ_MUL_BCD_EN
    ,
    output logic [4*DIGITS-1:0]  bcd
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] LAST_RUN = CW'(WIDTH - 1);
    localparam longint MAX_PROD = (longint'((1 << WIDTH) - 1)) * (longint'((1 << WIDTH) - 1));

    // Reject configurations whose product would overflow the operand or BCD range.
    if (WIDTH < 2 || WIDTH > 16 || longint'(10) ** DIGITS <= MAX_PROD) begin : g_param_check
        $error("seq_multiplier: illegal WIDTH/DIGITS combination");
    end

`ifdef SEQ_MUL_BCD_EN
    typedef enum logic [1:0] {IDLE, RUN, CONV, DONE} state_t;
    localparam logic [CW-1:0] LAST_CONV = CW'(PW - 1);
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t          state, next_state;
    logic [CW-1:0]   step;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic            last_run;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign last_run = (step == LAST_RUN);

`ifdef SEQ_MUL_BCD_EN
    logic [PW-1:0]         bin_sh;
    logic [4*DIGITS-1:0]   bcd_work;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shift;

    // Any digit of 5 or more is bumped by 3 so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[4*DIGITS-2:0], bin_sh[PW-1]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef SEQ_MUL_BCD_EN
                if (last_run) next_state = CONV;
`else
                if (last_run) next_state = DONE;
`endif
            end
`ifdef SEQ_MUL_BCD_EN
            CONV: begin
                busy = 1'b1;
                if (step == LAST_CONV) next_state = DONE;
            end
`endif
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The visible product/bcd registers load only on entry to DONE, never mid-operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            step     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            product  <= '0;
`ifdef SEQ_MUL_BCD_EN
            bin_sh   <= '0;
            bcd_work <= '0;
            bcd      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= PW'(a);
                        mplier <= b;
                        acc    <= '0;
                        step   <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + CW'(1);
                    if (last_run) begin
`ifdef SEQ_MUL_BCD_EN
                        bin_sh   <= acc_next;
                        bcd_work <= '0;
                        step     <= '0;
`else
                        product  <= acc_next;
`endif
                    end
                end
`ifdef SEQ_MUL_BCD_EN
                CONV: begin
                    bin_sh   <= bin_sh << 1;
                    bcd_work <= bcd_shift;
                    step     <= step + CW'(1);
                    if (step == LAST_CONV) begin
                        product <= acc;
                        bcd     <= bcd_shift;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a cycle-numbered reference model queues expected
// results and a negedge monitor compares busy/done/product (and bcd with SEQ_MUL_BCD_EN).
module tb_seq_multiplier;

    localparam int WIDTH  = 4;
    localparam int DIGITS = 3;
`ifdef SEQ_MUL_BCD_EN
    localparam int LAT = 3 * WIDTH;
`else
    localparam int LAT = WIDTH;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                busy;
    logic                done;
    logic [2*WIDTH-1:0]  product;
`ifdef SEQ_MUL_BCD_EN
    logic [4*DIGITS-1:0] bcd;
`endif

    seq_multiplier #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
`ifdef SEQ_MUL_BCD_EN
        .bcd     (bcd),
`endif
        .product (product)
    );

    typedef struct {
        int unsigned prod;
        int unsigned bcdv;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          edge_no = 0;
    int          next_ok = 0;
    int unsigned last_prod = 0;
    int          n_compared = 0;
    int          n_mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ref_bcd(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_no);
        end
    endtask

    // Reference model: an operation accepted at edge e finishes at edge e+LAT and
    // the next start can be taken at edge e+LAT+1; reset wipes everything.
    always @(posedge clk) begin : model
        int unsigned p;
        edge_no++;
        if (rst) begin
            exp_q.delete();
            next_ok   = edge_no + 1;
            last_prod = 0;
        end else if (start && edge_no >= next_ok) begin
            p = int'(a) * int'(b);
            exp_q.push_back('{prod: p, bcdv: ref_bcd(p), due: edge_no + LAT});
            next_ok = edge_no + LAT + 1;
        end
    end

    always @(negedge clk) begin : monitor
        logic exp_done;
        exp_t e;
        if (edge_no > 0) begin
            exp_done = (exp_q.size() > 0) && (exp_q[0].due == edge_no);
            checkOutput("busy", 32'(busy), 32'(edge_no < next_ok - 1));
            checkOutput("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                e = exp_q.pop_front();
                last_prod = e.prod;
            end
            checkOutput("product", 32'(product), last_prod);
`ifdef SEQ_MUL_BCD_EN
            checkOutput("bcd", 32'(bcd), ref_bcd(last_prod));
`endif
        end
    end

    task automatic waitReady();
        while (edge_no + 1 < next_ok) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        waitReady(); applyStimulus(4'd7, 4'd7);
        waitReady(); applyStimulus(4'd15, 4'd15);
        waitReady(); applyStimulus(4'd0, 4'd13);
        waitReady(); applyStimulus(4'd13, 4'd0);

        // A second start while running must be ignored.
        waitReady(); applyStimulus(4'd3, 4'd5);
        start = 1'b1; a = 4'd9; b = 4'd9;
        @(negedge clk);
        start = 1'b0;

        // Start held high across DONE: operands swapped on the DONE cycle.
        waitReady();
        start = 1'b1; a = 4'd2; b = 4'd6;
        @(negedge clk);
        while (edge_no + 1 < next_ok) @(negedge clk);
        a = 4'd4; b = 4'd4;
        @(negedge clk);
        start = 1'b0;

        // Reset during RUN step 2, then a fresh operation.
        waitReady(); applyStimulus(4'd11, 4'd12);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitReady(); applyStimulus(4'd5, 4'd6);

        // Reset must win over a simultaneous start.
        waitReady();
        rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, LAT + 2)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom));
        end

        repeat (LAT + 4) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Parameter: DIGITS, default 3, number of BCD digits on bcd; SHALL satisfy 10^DIGITS > (2^WIDTH-1)^2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-006 Port: a  input  WIDTH  multiplicand, unsigned; captured on the accepted start.
REQ-007 Port: b  input  WIDTH  multiplier, unsigned; captured on the accepted start.
REQ-008 Port: busy  output  1  high while an operation is in progress (RUN or CONV).
REQ-009 Port: done  output  1  one-cycle pulse when product (and bcd) become valid.
REQ-010 Port: product  output  2*WIDTH  unsigned a*b; held stable from done until the next accepted start.
REQ-011 Port (only with SEQ_MUL_BCD_EN): bcd  output  4*DIGITS  packed BCD of product, digit 0 in bits [3:0].

Function
REQ-012 FSM states: IDLE, RUN, CONV (only with SEQ_MUL_BCD_EN), DONE.
REQ-013 IDLE: start=1 -> capture a, b, clear the accumulator and the step counter, go to RUN; start=0 -> stay in IDLE.
REQ-014 RUN, shift-and-add, one multiplier bit per cycle, LSB first:
- if the current multiplier bit is 1, add a<<step into a 2*WIDTH-bit accumulator with no overflow loss;
- step counter increments each cycle;
- after exactly WIDTH RUN cycles, go to CONV (if SEQ_MUL_BCD_EN) or DONE.
REQ-015 CONV: shift-add-3 (double-dabble) conversion of the final product, one bit per cycle; after exactly 2*WIDTH cycles, go to DONE.
REQ-016 DONE lasts one cycle:
- done=1; product (and bcd) hold the result;
- start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
REQ-017 Latency, start accepted at edge 0:
- without SEQ_MUL_BCD_EN, done is high in the cycle after edge WIDTH;
- with SEQ_MUL_BCD_EN, done is high in the cycle after edge 3*WIDTH.
REQ-018 Start, a and b are ignored while busy=1; changes to a or b after capture do not affect the result.
REQ-019 product updates only on the transition into DONE; it never exposes partial sums.
REQ-020 busy=1 exactly in RUN and CONV; done and busy are never high together.
REQ-021 Operand 0 on either input still takes the full latency and yields product 0.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, product=0 and bcd=0, overriding start in the same cycle.
REQ-023 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after rst is released is accepted normally.

Configuration
REQ-024 Macro SEQ_MUL_BCD_EN defined: the bcd port, the CONV state and the converter are compiled in; latency per REQ-017.
REQ-025 Macro SEQ_MUL_BCD_EN undefined: no bcd port and no CONV state; RUN goes directly to DONE; all other behaviour is identical.

Verification
REQ-026 WIDTH=4, no macro: a=7, b=7, start pulse -> busy high 4 cycles, then done pulse with product=49 (0x31) in cycle 5.
REQ-027 WIDTH=4, macro on: a=15, b=15 -> done in cycle 13, product=225 (0xE1), bcd=0x225.
REQ-028 a=0, b=13 -> done after full latency, product=0, bcd=0x000; then a=13, b=0 -> product=0.
REQ-029 a=3, b=5 started; start re-pulsed with a=9, b=9 during RUN -> ignored, product=15.
REQ-030 start held high continuously with a=2, b=6 then a=4, b=4 on the DONE cycle -> products 12 then 16, one done pulse each, no IDLE cycle between.
REQ-031 rst asserted for 1 cycle at RUN step 2 -> no done pulse, outputs zero, next start a=5, b=6 -> product=30.
